// File: rtl/text_buffer_pkg.sv
// Shared constants, FSM state type and address helpers for the text buffer.
// Optional blinking cursor is enabled with TEXT_BUFFER_CURSOR_EN (see text_buffer.sv).
package text_buffer_pkg;

  localparam int TEXT_COLS  = 80;
  localparam int TEXT_ROWS  = 60;
  localparam int CELL_COUNT = TEXT_COLS * TEXT_ROWS;
  localparam int ADDR_W     = 13;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [7:0] CURSOR_CHAR = 8'h5F;
  localparam int         BLINK_LOG2  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR_LINE,
    ST_CLR_SCREEN
  } state_t;

  // row*80 as (row<<6)+(row<<4), kept shift-and-add so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] row, input logic [6:0] col);
    return {row, 6'b0} + {2'b0, row, 4'b0} + {6'b0, col};
  endfunction

  function automatic logic [5:0] next_row(input logic [5:0] row);
    return (row == 6'(TEXT_ROWS - 1)) ? 6'd0 : row + 6'd1;
  endfunction

endpackage

// File: rtl/text_buffer_if.sv
// Byte-stream write handshake into the text buffer.
interface text_buffer_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/text_buffer_char_ram.sv
// Simple dual-port character RAM: registered read port, write port, one clock.
module char_ram #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Non-blocking read and write in one process give read-before-write on a collision
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/text_buffer.sv
// 80x60 text store written by a terminal byte stream, read by pixel position.
// Define TEXT_BUFFER_CURSOR_EN to overlay a blinking cursor on the display output.
module text_buffer
  import text_buffer_pkg::*;
(
  input  logic         px_clk,
  input  logic         rst_n,
  input  logic [9:0]   pos_x,
  input  logic [9:0]   pos_y,
  output logic [7:0]   character,
  output logic [9:0]   out_pos_x,
  output logic [9:0]   out_pos_y,
  text_buffer_if.slave wr,
  output logic [6:0]   cursor_col,
  output logic [5:0]   cursor_row
);

  state_t             state, state_next;
  logic [6:0]         col_next;
  logic [5:0]         row_next;
  logic [ADDR_W-1:0]  clr_cnt, clr_next;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr, ram_raddr;
  logic [7:0]         ram_wdata, ram_rdata;
  logic [6:0]         disp_col, disp_row;
  logic               disp_blank, blank_q;

  assign wr.wr_ready = (state == ST_IDLE);

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLR_SCREEN;
      cursor_col <= '0;
      cursor_row <= '0;
      clr_cnt    <= '0;
    end else begin
      state      <= state_next;
      cursor_col <= col_next;
      cursor_row <= row_next;
      clr_cnt    <= clr_next;
    end
  end

  always_comb begin
    state_next = state;
    col_next   = cursor_col;
    row_next   = cursor_row;
    clr_next   = clr_cnt;
    ram_we     = 1'b0;
    ram_waddr  = cell_addr({1'b0, cursor_row}, cursor_col);
    ram_wdata  = CH_SPACE;
    case (state)
      ST_IDLE: begin
        clr_next = '0;
        if (wr.wr_valid) begin
          if (wr.wr_data >= 8'h20 && wr.wr_data <= 8'h7E) begin
            ram_we    = 1'b1;
            ram_wdata = wr.wr_data;
            if (cursor_col == 7'(TEXT_COLS - 1)) begin
              col_next   = '0;
              row_next   = next_row(cursor_row);
              state_next = ST_CLR_LINE;
            end else begin
              col_next = cursor_col + 7'd1;
            end
          end else begin
            case (wr.wr_data)
              CH_CR: col_next = '0;
              CH_LF: begin
                col_next   = '0;
                row_next   = next_row(cursor_row);
                state_next = ST_CLR_LINE;
              end
              CH_BS: begin
                if (cursor_col != 7'd0) begin
                  col_next  = cursor_col - 7'd1;
                  ram_we    = 1'b1;
                  ram_waddr = cell_addr({1'b0, cursor_row}, cursor_col - 7'd1);
                end
              end
              CH_FF:   state_next = ST_CLR_SCREEN;
              default: ;
            endcase
          end
        end
      end
      // Cursor row already points at the freshly entered line
      ST_CLR_LINE: begin
        ram_we    = 1'b1;
        ram_waddr = cell_addr({1'b0, cursor_row}, clr_cnt[6:0]);
        clr_next  = clr_cnt + 13'd1;
        if (clr_cnt == 13'(TEXT_COLS - 1)) state_next = ST_IDLE;
      end
      ST_CLR_SCREEN: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt;
        clr_next  = clr_cnt + 13'd1;
        if (clr_cnt == 13'(CELL_COUNT - 1)) begin
          state_next = ST_IDLE;
          col_next   = '0;
          row_next   = '0;
        end
      end
      default: state_next = ST_CLR_SCREEN;
    endcase
  end

  assign disp_col   = pos_x[9:3];
  assign disp_row   = pos_y[9:3];
  assign disp_blank = (disp_col >= 7'(TEXT_COLS)) || (disp_row >= 7'(TEXT_ROWS));
  assign ram_raddr  = cell_addr(disp_row, disp_col);

  char_ram #(.ADDR_WIDTH(ADDR_W), .DATA_WIDTH(8)) u_char_ram (
    .clk   (px_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Position and blank flag are delayed alongside the one-cycle RAM read
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pos_x <= '0;
      out_pos_y <= '0;
      blank_q   <= 1'b1;
    end else begin
      out_pos_x <= pos_x;
      out_pos_y <= pos_y;
      blank_q   <= disp_blank;
    end
  end

`ifdef TEXT_BUFFER_CURSOR_EN
  typedef logic [BLINK_LOG2:0] frame_t;
  frame_t frame_cnt;
  logic   cursor_hit_q;

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt    <= '0;
      cursor_hit_q <= 1'b0;
    end else begin
      if (pos_x == 10'd0 && pos_y == 10'd0) frame_cnt <= frame_cnt + frame_t'(1);
      cursor_hit_q <= !disp_blank && (disp_col == cursor_col) && (disp_row == {1'b0, cursor_row});
    end
  end

  assign character = blank_q ? CH_SPACE :
                     (cursor_hit_q && frame_cnt[BLINK_LOG2]) ? CURSOR_CHAR : ram_rdata;
`else
  assign character = blank_q ? CH_SPACE : ram_rdata;
`endif

endmodule

// File: tb/tb_text_buffer.sv
// Directed self-checking bench for text_buffer: write stream, clears, display read.
module tb_text_buffer;

  logic       px_clk = 1'b0;
  logic       rst_n;
  logic [9:0] pos_x, pos_y;
  logic [7:0] character;
  logic [9:0] out_pos_x, out_pos_y;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  int         checks = 0;
  int         passes = 0;

`ifdef TEXT_BUFFER_CURSOR_EN
  localparam logic [7:0] BLINK_ON_EXP = 8'h5F;
`else
  localparam logic [7:0] BLINK_ON_EXP = 8'h20;
`endif

  text_buffer_if wr_if ();

  text_buffer dut (
    .px_clk     (px_clk),
    .rst_n      (rst_n),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .character  (character),
    .out_pos_x  (out_pos_x),
    .out_pos_y  (out_pos_y),
    .wr         (wr_if),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 px_clk = ~px_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Present one byte and hold it until accepted; returns at the negedge after acceptance
  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    @(negedge px_clk);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = b;
    while (!wr_if.wr_ready && n < 10000) begin
      @(negedge px_clk);
      n++;
    end
    if (!wr_if.wr_ready) checkOutput("accept_timeout", 32'(n), 32'd0);
    @(negedge px_clk);
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic measureBusy(output int cycles);
    cycles = 0;
    while (!wr_if.wr_ready && cycles < 6000) begin
      cycles++;
      @(negedge px_clk);
    end
  endtask

  task automatic checkPix(input string tag, input int x, input int y, input logic [7:0] exp);
    @(negedge px_clk);
    pos_x = 10'(x);
    pos_y = 10'(y);
    @(negedge px_clk);
    checkOutput(tag, 32'(character), 32'(exp));
  endtask

  initial begin
    int busy;
    rst_n          = 1'b0;
    pos_x          = 10'd100;
    pos_y          = 10'd50;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 8'h41;
    repeat (3) @(negedge px_clk);
    checkOutput("rst_out_pos_x", 32'(out_pos_x), 32'd0);
    checkOutput("rst_out_pos_y", 32'(out_pos_y), 32'd0);
    checkOutput("rst_character", 32'(character), 32'h20);
    checkOutput("rst_wr_ready", 32'(wr_if.wr_ready), 32'd0);
    checkOutput("rst_cursor", {19'd0, cursor_row, cursor_col}, 32'd0);

    // 'A' held valid through the power-on clear
    rst_n = 1'b1;
    measureBusy(busy);
    checkOutput("init_clear_busy", 32'(busy), 32'd4800);
    @(negedge px_clk);
    wr_if.wr_valid = 1'b0;
    checkOutput("A_cursor_col", 32'(cursor_col), 32'd1);
    checkPix("A_cell_0_0", 0, 0, 8'h41);
    checkPix("A_cell_px_7_7", 7, 7, 8'h41);

    applyStimulus(8'h0D);
    applyStimulus(8'h48);
    applyStimulus(8'h49);
    applyStimulus(8'h0D);
    applyStimulus(8'h4A);
    checkPix("HICRJ_cell_0", 0, 0, 8'h4A);
    checkPix("HICRJ_cell_1", 8, 0, 8'h49);
    checkOutput("HICRJ_col", 32'(cursor_col), 32'd1);

    applyStimulus(8'h0A);
    measureBusy(busy);
    checkOutput("lf_busy", 32'(busy), 32'd80);
    checkOutput("lf_cursor", {19'd0, cursor_row, cursor_col}, {19'd0, 6'd1, 7'd0});
    applyStimulus(8'h5A);
    applyStimulus(8'h5A);
    for (int i = 0; i < 58; i++) applyStimulus(8'h0A);
    measureBusy(busy);
    checkOutput("lf58_row", 32'(cursor_row), 32'd59);

    // LF on the last row wraps to row 0 and clears it
    applyStimulus(8'h0A);
    measureBusy(busy);
    checkOutput("wrap_lf_busy", 32'(busy), 32'd80);
    checkOutput("wrap_lf_cursor", {19'd0, cursor_row, cursor_col}, 32'd0);
    checkPix("wrap_row0_c0", 0, 0, 8'h20);
    checkPix("wrap_row0_c1", 8, 0, 8'h20);
    checkPix("wrap_row1_kept", 0, 8, 8'h5A);

    for (int i = 0; i < 79; i++) applyStimulus(8'h78);
    applyStimulus(8'h78);
    measureBusy(busy);
    checkOutput("autowrap_busy", 32'(busy), 32'd80);
    checkOutput("autowrap_cursor", {19'd0, cursor_row, cursor_col}, {19'd0, 6'd1, 7'd0});
    checkPix("autowrap_row1_c0", 0, 8, 8'h20);
    checkPix("autowrap_row1_c1", 8, 8, 8'h20);
    checkPix("autowrap_row0_c79", 632, 0, 8'h78);
    checkPix("autowrap_row0_c40", 320, 0, 8'h78);

    applyStimulus(8'h08);
    checkOutput("bs_col0_cursor", {19'd0, cursor_row, cursor_col}, {19'd0, 6'd1, 7'd0});
    checkOutput("bs_col0_ready", 32'(wr_if.wr_ready), 32'd1);
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h08);
    checkOutput("bs_col", 32'(cursor_col), 32'd1);
    checkPix("bs_erased", 8, 8, 8'h20);
    checkPix("bs_kept", 7, 15, 8'h41);
    applyStimulus(8'h01);
    checkOutput("ignored_code_col", 32'(cursor_col), 32'd1);

    checkPix("blank_x700", 700, 0, 8'h20);
    checkPix("blank_y480", 0, 480, 8'h20);
    checkPix("edge_x639", 639, 7, 8'h78);

    for (int i = 0; i < 5; i++) begin
      @(negedge px_clk);
      pos_x = 10'(i * 3 + 2);
      pos_y = 10'(i * 7 + 1);
      @(negedge px_clk);
      checkOutput("lat_out_pos_x", 32'(out_pos_x), 32'(i * 3 + 2));
      checkOutput("lat_out_pos_y", 32'(out_pos_y), 32'(i * 7 + 1));
    end

    applyStimulus(8'h0C);
    measureBusy(busy);
    checkOutput("ff_busy", 32'(busy), 32'd4800);
    checkOutput("ff_cursor", {19'd0, cursor_row, cursor_col}, 32'd0);
    checkPix("ff_row1", 0, 8, 8'h20);
    checkPix("ff_row0_c79", 632, 0, 8'h20);

    // Reset in the middle of a screen clear restarts the full clear
    applyStimulus(8'h51);
    applyStimulus(8'h0C);
    repeat (100) @(negedge px_clk);
    pos_x = 10'd8;
    pos_y = 10'd8;
    rst_n = 1'b0;
    @(negedge px_clk);
    checkOutput("midrst_ready", 32'(wr_if.wr_ready), 32'd0);
    checkOutput("midrst_col", 32'(cursor_col), 32'd0);
    checkOutput("midrst_character", 32'(character), 32'h20);
    rst_n = 1'b1;
    measureBusy(busy);
    checkOutput("midrst_busy", 32'(busy), 32'd4800);

    // 32 frame starts put the blink phase on
    pos_x = 10'd0;
    pos_y = 10'd0;
    repeat (32) @(negedge px_clk);
    checkPix("blink_on_cursor", 0, 0, BLINK_ON_EXP);
    checkPix("blink_on_other", 8, 0, 8'h20);
    @(negedge px_clk);
    pos_x = 10'd0;
    pos_y = 10'd0;
    repeat (31) @(negedge px_clk);
    checkPix("blink_off_cursor", 0, 0, 8'h20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/text_buffer.md
# text_buffer

Text-mode character store and fetch stage sitting directly upstream of the font renderer. Holds an 80×60 grid of 8-bit character codes, written by a terminal-style byte stream (cursor, CR/LF, backspace, clear), and on the display side turns the pixel position into the character code under it. Its outputs are one pixel clock late and come with the matching delayed pixel position, so the font stage receives character, pos_x and pos_y already aligned.

## Interface
- COLS, 80: text columns (8-px cells, 640 px).
- ROWS, 60: text rows (8-px cells, 480 px).
- CURSOR_CHAR, 8'h5F: code substituted at the cursor cell while blink is on (CURSOR_EN only).
- BLINK_LOG2, 5: blink half-period = 2^BLINK_LOG2 frames (CURSOR_EN only).

- px_clk  in  1  pixel clock, sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- pos_x  in  10  current screen X.
- pos_y  in  10  current screen Y.
- character  out  8  code of the cell under (out_pos_x, out_pos_y).
- out_pos_x  out  10  pos_x delayed 1 cycle.
- out_pos_y  out  10  pos_y delayed 1 cycle.
- wr_valid  in  1  byte available.
- wr_data  in  8  byte to print or control code.
- wr_ready  out  1  block accepts wr_data this cycle.
- cursor_col  out  7  current cursor column, 0..COLS-1.
- cursor_row  out  6  current cursor row, 0..ROWS-1.

## Operation
- Cell address = row*COLS + col, with row*80 computed as (row<<6)+(row<<4). Width is 13 bits.
- Display read:
  - col = pos_x[9:3], row = pos_y[9:3].
  - If col ≥ COLS or row ≥ ROWS, the cell is blank and character is 8'h20.
  - The read port is always enabled.
- Write stream: a byte transfers on wr_valid && wr_ready. FSM states:
  - IDLE: wr_ready=1. Action on the accepted byte:
    - 0x20..0x7E: write to the cursor cell and advance col. At col=COLS-1 the cursor auto-wraps (same as LF).
    - 0x0D (CR): col←0.
    - 0x0A (LF): col←0; row←(row+1) mod ROWS; go to CLR_LINE.
    - 0x08 (BS): if col>0, col←col-1 and write 0x20 at the new col. If col=0, no operation.
    - 0x0C (FF): go to CLR_SCREEN.
    - All other codes: accepted and ignored.
  - CLR_LINE: wr_ready=0. Writes 0x20 to the COLS cells of the new cursor row, one per cycle, then returns to IDLE.
  - CLR_SCREEN: wr_ready=0. Writes 0x20 to all COLS*ROWS cells, one per cycle, then sets cursor to (0,0) and returns to IDLE.
- Auto-wrap or LF on the last row wraps the cursor to row 0. There is no scrolling.
- Reset: the FSM enters CLR_SCREEN when rst_n deasserts. RAM contents are undefined until that clear completes.
- Reset asserted mid-clear aborts the clear. The clear restarts from address 0 after release.

## Timing
- Display latency is exactly 1 cycle: character, out_pos_x and out_pos_y all correspond to pos_x/pos_y of the previous cycle.
- Same-cycle read and write to one cell: the read returns the old data (read-before-write).
- Only the write port is ever written. A display read never stalls the write path.
- wr_ready is a registered state decode and does not depend combinationally on wr_valid.
- After an LF, wr_ready is low for exactly COLS cycles.
- After an FF, wr_ready is low for exactly COLS*ROWS cycles.
- Reset values:
  - out_pos_x=0, out_pos_y=0.
  - character=8'h20 (blank flag reset to 1).
  - wr_ready=0 (CLR_SCREEN).
  - cursor_col=0, cursor_row=0.

## Configuration
- TEXT_BUFFER_CURSOR_EN defined:
  - A frame counter increments on each cycle with pos_x==0 && pos_y==0.
  - While counter bit BLINK_LOG2 is 1 and the read cell equals the cursor cell, character=CURSOR_CHAR.
  - The counter resets to 0.
- TEXT_BUFFER_CURSOR_EN undefined: no counter; character is always the stored code (or blank).

## Structure
- Shared package/header (const.vh style):
  - TEXT_COLS, TEXT_ROWS.
  - Control-code constants CH_BS, CH_LF, CH_FF, CH_CR.
  - CH_SPACE.
  - FSM state encodings ST_IDLE, ST_CLR_LINE, ST_CLR_SCREEN.
- One sub-module, char_ram: simple dual-port RAM with a registered read port and a write port on px_clk.
  - addr_width=13, data_width=8.
  - Instantiated once.

## Test plan
- Release reset, hold wr_valid=1 with 'A' → wr_ready stays 0 for 4800 cycles. Then 'A' is accepted and character=8'h41 at cell (0,0) one cycle after pos=(0..7,0..7).
- Write "HI", CR, "J" → cell (0,0)=0x4A, (1,0)=0x49, cursor_col=1.
- Write 80 × 'x' from col 0 → cursor moves to (0,1) and wr_ready is low for 80 cycles. Row 1 reads all 0x20.
- Cursor at (0,59), send LF → cursor (0,0), row 0 cleared to 0x20, wr_ready low 80 cycles.
- BS at col 0 → no change. "AB", BS → cursor_col=1, cell (1,row)=0x20.
- pos_x=700 → character=0x20. pos_y stepping: out_pos_y equals pos_y delayed 1 cycle. With TEXT_BUFFER_CURSOR_EN, the cursor cell reads 0x5F during frames 32..63.
